rmii_phy_speed_ctrl: RTL and testbench



---
 rtl/rmii_phy_speed_ctrl_if.sv | 10 +
 rtl/rmii_phy_speed_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rmii_phy_speed_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rmii_phy_speed_ctrl_if.sv
// MDIO management bus between the speed controller (master) and the PHY pad side (slave).
interface rmii_phy_speed_ctrl_if;
  logic mdc;
  logic mdio_o;
  logic mdio_oe;
  logic mdio_i;

  modport master (output mdc, output mdio_o, output mdio_oe, input mdio_i);
  modport slave  (input mdc, input mdio_o, input mdio_oe, output mdio_i);
endinterface

// File: rtl/rmii_phy_speed_ctrl.sv
// Polls an RMII PHY over MDIO for link and speed, then debounces the result and
// drives the bridge speed conduit and reset.
module rmii_phy_speed_ctrl #(
  parameter logic [4:0] PHY_ADDR    = 5'd0,
  parameter int         MDC_DIV     = 10,
  parameter int         POLL_CYCLES = 5_000_000,
  parameter logic [4:0] SPD_REG     = 5'd31,
  parameter int         SPD_BIT     = 3
) (
  input  logic                         clk_50m,
  input  logic                         rst_n,
  rmii_phy_speed_ctrl_if.master        mdio,
  output logic [2:0]                   eth_speed,
  output logic                         link_up,
  output logic                         bridge_rst_n,
  output logic                         phy_err
);
  localparam int DW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

  typedef enum logic [1:0] {WAIT, RD_STAT, RD_SPD, EVAL} state_t;

  state_t        state_q, state_d;
  logic [22:0]   timer_q, timer_d;
  logic [2:0]    cand_q, cand_d;
  logic          err_q, err_d;
  logic          start;

  logic          busy_q, mdc_q, mdo_q, moe_q;
  logic [DW-1:0] div_q;
  logic [5:0]    bit_q, nxt_bit;
  logic          ta_q, lnk_q, spd_q;
  logic          tick, frame_done;
  logic [4:0]    reg_sel;
  logic [63:0]   frame_w;

  logic [2:0]    speed_q, prev_q;
  logic [4:0]    brst_q;
  logic          chg;

  // TA and data positions are ones so mdio_o idles high once released.
  assign reg_sel    = (state_q == RD_SPD) ? SPD_REG : 5'd1;
  assign frame_w    = {32'hFFFF_FFFF, 4'b0110, PHY_ADDR, reg_sel, 18'h3FFFF};
  assign tick       = busy_q && (div_q == DW'(MDC_DIV - 1));
  assign frame_done = tick && mdc_q && (bit_q == 6'd63);
  assign nxt_bit    = bit_q + 6'd1;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mdc_q  <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      mdo_q  <= 1'b1;
      moe_q  <= 1'b0;
      ta_q   <= 1'b1;
      lnk_q  <= 1'b0;
      spd_q  <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      mdc_q  <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      mdo_q  <= frame_w[63];
      moe_q  <= 1'b1;
    end else if (busy_q) begin
      if (tick) begin
        div_q <= '0;
        mdc_q <= ~mdc_q;
        if (!mdc_q) begin
          // rising MDC: sample only the bits the FSM consumes
          if (bit_q == 6'd47)                ta_q  <= mdio.mdio_i;
          if (bit_q == 6'd61)                lnk_q <= mdio.mdio_i;
          if (bit_q == 6'(63 - SPD_BIT))     spd_q <= mdio.mdio_i;
        end else if (bit_q == 6'd63) begin
          busy_q <= 1'b0;
        end else begin
          bit_q <= nxt_bit;
          mdo_q <= frame_w[6'd63 - nxt_bit];
          moe_q <= (nxt_bit < 6'd46);
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      timer_q <= '0;
      cand_q  <= 3'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cand_q  <= cand_d;
      err_q   <= err_d;
    end
  end

  // Timer resets to zero, so the first poll launches on the first cycle out of reset.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cand_d  = cand_q;
    err_d   = err_q;
    start   = 1'b0;
    case (state_q)
      WAIT: begin
        if (timer_q == 23'd0) begin
          state_d = RD_STAT;
          start   = 1'b1;
        end else begin
          timer_d = timer_q - 23'd1;
        end
      end
      RD_STAT: begin
        if (frame_done) begin
          err_d = ta_q;
          if (ta_q || !lnk_q) begin
            cand_d  = 3'h0;
            state_d = EVAL;
          end else begin
            state_d = RD_SPD;
            start   = 1'b1;
          end
        end
      end
      RD_SPD: begin
        if (frame_done) begin
          err_d   = ta_q;
          cand_d  = ta_q ? 3'h0 : (spd_q ? 3'h2 : 3'h1);
          state_d = EVAL;
        end
      end
      EVAL: begin
        state_d = WAIT;
        timer_d = 23'(POLL_CYCLES - 1);
      end
      default: state_d = WAIT;
    endcase
  end

  assign chg = (state_q == EVAL) && (cand_q == prev_q) && (cand_q != speed_q);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= 3'h0;
      prev_q  <= 3'h0;
      brst_q  <= '0;
    end else begin
      if (state_q == EVAL) prev_q <= cand_q;
      if (chg) begin
        speed_q <= cand_q;
        brst_q  <= 5'd16;
      end else if (brst_q != 5'd0) begin
        brst_q  <= brst_q - 5'd1;
      end
    end
  end

  assign mdio.mdc     = mdc_q;
  assign mdio.mdio_o  = mdo_q;
  assign mdio.mdio_oe = moe_q;
  assign eth_speed    = speed_q;
  assign link_up      = (speed_q != 3'h0);
  assign bridge_rst_n = (brst_q == 5'd0) && (speed_q != 3'h0);
  assign phy_err      = err_q;
endmodule

// File: tb/tb_rmii_phy_speed_ctrl.sv
// Directed bench: behavioural MDIO PHY plus per-feature tasks with hand-computed expectations.
module tb_rmii_phy_speed_ctrl;
  localparam int         POLL  = 100;
  localparam logic [4:0] PADDR = 5'd5;
  localparam logic [45:0] EXP_STAT = {32'hFFFF_FFFF, 4'b0110, 5'd5, 5'd1};
  localparam logic [45:0] EXP_SPD  = {32'hFFFF_FFFF, 4'b0110, 5'd5, 5'd31};

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] eth_speed;
  logic       link_up, bridge_rst_n, phy_err;

  rmii_phy_speed_ctrl_if ifc ();

  rmii_phy_speed_ctrl #(
    .PHY_ADDR(PADDR), .MDC_DIV(10), .POLL_CYCLES(POLL), .SPD_REG(5'd31), .SPD_BIT(3)
  ) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .mdio         (ifc),
    .eth_speed    (eth_speed),
    .link_up      (link_up),
    .bridge_rst_n (bridge_rst_n),
    .phy_err      (phy_err)
  );

  always #10 clk_50m = ~clk_50m;

  int checks = 0;
  int errors = 0;

  logic [15:0] bmsr = 16'h0004;
  logic [15:0] reg31 = 16'h0008;
  logic        phy_present = 1'b1;
  logic        phy_mdio = 1'b1;
  assign ifc.mdio_i = phy_mdio;

  int cyc = 0;
  always @(posedge clk_50m) cyc++;

  // PHY model and monitors, sampled on the falling clock edge
  int          bitcnt = 0, frames_start = 0, frames_end = 0;
  int          bad_per = 0, oe_err = 0, oe_fall_bit = -1, last_rise = 0;
  int          chg_cyc = 0, rise_len = -1, rise_cnt = 0, sync_err = 0;
  logic [45:0] cap = '0;
  logic        mdc_prev = 1'b0, oe_prev = 1'b0, brn_prev = 1'b0;
  logic [2:0]  spd_prev = 3'h0;
  logic [15:0] rd;

  always @(negedge clk_50m) begin
    if (ifc.mdio_oe && !oe_prev) begin
      bitcnt = 0;
      frames_start++;
    end
    if (!ifc.mdio_oe && oe_prev) oe_fall_bit = bitcnt;
    if (ifc.mdc && !mdc_prev) begin
      if (bitcnt > 0 && (cyc - last_rise) != 20) bad_per++;
      last_rise = cyc;
      if (bitcnt < 46) begin
        cap = {cap[44:0], ifc.mdio_o};
        if (!ifc.mdio_oe) oe_err++;
      end else if (ifc.mdio_oe || !ifc.mdio_o) oe_err++;
      bitcnt++;
      if (bitcnt == 64) frames_end++;
    end
    if (!ifc.mdc && mdc_prev) begin
      rd = (cap[4:0] == 5'd1) ? bmsr : (cap[4:0] == 5'd31) ? reg31 : 16'hFFFF;
      if (!phy_present)                  phy_mdio = 1'b1;
      else if (bitcnt == 47)             phy_mdio = 1'b0;
      else if (bitcnt >= 48 && bitcnt <= 63) phy_mdio = rd[63 - bitcnt];
      else                               phy_mdio = 1'b1;
    end
    if (eth_speed !== spd_prev) begin
      chg_cyc = cyc;
      if (bridge_rst_n !== 1'b0) sync_err++;
    end
    if (bridge_rst_n && !brn_prev) begin
      rise_len = cyc - chg_cyc;
      rise_cnt++;
    end
    mdc_prev = ifc.mdc;
    oe_prev  = ifc.mdio_oe;
    spd_prev = eth_speed;
    brn_prev = bridge_rst_n;
  end

  task automatic wait_frames(input int n);
    int tgt;
    int t;
    tgt = frames_end + n;
    t = 0;
    while (frames_end < tgt && t < n * 3000) begin
      @(negedge clk_50m);
      t++;
    end
    checks++;
    if (frames_end < tgt) begin
      $display("FAIL frame_timeout: frames %0d, required %0d", frames_end, tgt);
      errors++;
    end
    repeat (15) @(negedge clk_50m);
  endtask

  task automatic test_reset();
    bit found;
    repeat (3) @(negedge clk_50m);
    checks++; if (ifc.mdc !== 1'b0)     begin $display("FAIL rst_mdc: got %b, required 0", ifc.mdc); errors++; end
    checks++; if (ifc.mdio_o !== 1'b1)  begin $display("FAIL rst_mdio_o: got %b, required 1", ifc.mdio_o); errors++; end
    checks++; if (ifc.mdio_oe !== 1'b0) begin $display("FAIL rst_mdio_oe: got %b, required 0", ifc.mdio_oe); errors++; end
    checks++; if (eth_speed !== 3'h0)   begin $display("FAIL rst_speed: got %h, required 0", eth_speed); errors++; end
    checks++; if (link_up !== 1'b0)     begin $display("FAIL rst_link: got %b, required 0", link_up); errors++; end
    checks++; if (bridge_rst_n !== 1'b0) begin $display("FAIL rst_bridge: got %b, required 0", bridge_rst_n); errors++; end
    checks++; if (phy_err !== 1'b0)     begin $display("FAIL rst_phy_err: got %b, required 0", phy_err); errors++; end
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_50m); #1;
      if (ifc.mdio_oe) found = 1'b1;
    end
    checks++; if (!found) begin $display("FAIL first_poll_start: oe %b, required 1 within 2 cycles", ifc.mdio_oe); errors++; end
  endtask

  task automatic test_frame_format();
    wait_frames(1);
    checks++; if (cap !== EXP_STAT) begin $display("FAIL frame_stat_bits: got %h, required %h", cap, EXP_STAT); errors++; end
    checks++; if (bad_per != 0)     begin $display("FAIL mdc_period: %0d bad periods, required 0", bad_per); errors++; end
    checks++; if (oe_err != 0)      begin $display("FAIL oe_window: %0d bad bits, required 0", oe_err); errors++; end
    checks++; if (oe_fall_bit != 46) begin $display("FAIL oe_fall_bit: got %0d, required 46", oe_fall_bit); errors++; end
    wait_frames(1);
    checks++; if (cap !== EXP_SPD)  begin $display("FAIL frame_spd_bits: got %h, required %h", cap, EXP_SPD); errors++; end
    checks++; if (eth_speed !== 3'h0) begin $display("FAIL poll1_speed: got %h, required 0", eth_speed); errors++; end
    checks++; if (phy_err !== 1'b0) begin $display("FAIL poll1_phy_err: got %b, required 0", phy_err); errors++; end
  endtask

  task automatic test_link_100();
    int rc;
    rc = rise_cnt;
    wait_frames(2);
    checks++; if (eth_speed !== 3'h2) begin $display("FAIL l100_speed: got %h, required 2", eth_speed); errors++; end
    checks++; if (link_up !== 1'b1)   begin $display("FAIL l100_link: got %b, required 1", link_up); errors++; end
    repeat (20) @(negedge clk_50m);
    checks++; if (rise_cnt != rc + 1 || rise_len != 16) begin
      $display("FAIL l100_bridge_low: len %0d rises %0d, required len 16 rises %0d", rise_len, rise_cnt, rc + 1); errors++; end
    checks++; if (bridge_rst_n !== 1'b1) begin $display("FAIL l100_bridge_high: got %b, required 1", bridge_rst_n); errors++; end
    checks++; if (sync_err != 0) begin $display("FAIL l100_bridge_sync: %0d, required 0", sync_err); errors++; end
  endtask

  task automatic test_speed_change();
    int rc;
    reg31 = 16'h0000;
    wait_frames(2);
    checks++; if (eth_speed !== 3'h2) begin $display("FAIL glitch_speed: got %h, required 2", eth_speed); errors++; end
    reg31 = 16'h0008;
    wait_frames(2);
    checks++; if (eth_speed !== 3'h2) begin $display("FAIL glitch_back_speed: got %h, required 2", eth_speed); errors++; end
    reg31 = 16'hFFF7;
    wait_frames(2);
    checks++; if (eth_speed !== 3'h2) begin $display("FAIL m10_poll1_speed: got %h, required 2", eth_speed); errors++; end
    rc = rise_cnt;
    wait_frames(2);
    checks++; if (eth_speed !== 3'h1) begin $display("FAIL m10_poll2_speed: got %h, required 1", eth_speed); errors++; end
    checks++; if (link_up !== 1'b1)   begin $display("FAIL m10_link: got %b, required 1", link_up); errors++; end
    repeat (20) @(negedge clk_50m);
    checks++; if (rise_cnt != rc + 1 || rise_len != 16) begin
      $display("FAIL m10_bridge_low: len %0d rises %0d, required len 16 rises %0d", rise_len, rise_cnt, rc + 1); errors++; end
    checks++; if (sync_err != 0) begin $display("FAIL m10_bridge_sync: %0d, required 0", sync_err); errors++; end
  endtask

  task automatic test_link_drop();
    reg31 = 16'h0008;
    wait_frames(2);
    wait_frames(2);
    checks++; if (eth_speed !== 3'h2) begin $display("FAIL drop_pre_speed: got %h, required 2", eth_speed); errors++; end
    bmsr = 16'hFFFB;
    wait_frames(1);
    checks++; if (eth_speed !== 3'h2) begin $display("FAIL drop_poll1_speed: got %h, required 2", eth_speed); errors++; end
    wait_frames(1);
    checks++; if (eth_speed !== 3'h0) begin $display("FAIL drop_speed: got %h, required 0", eth_speed); errors++; end
    checks++; if (link_up !== 1'b0)   begin $display("FAIL drop_link: got %b, required 0", link_up); errors++; end
    repeat (30) @(negedge clk_50m);
    checks++; if (bridge_rst_n !== 1'b0) begin $display("FAIL drop_bridge: got %b, required 0", bridge_rst_n); errors++; end
  endtask

  task automatic test_no_phy();
    int fs;
    bmsr = 16'h0004;
    reg31 = 16'h0008;
    wait_frames(2);
    wait_frames(2);
    checks++; if (eth_speed !== 3'h2) begin $display("FAIL nophy_pre_speed: got %h, required 2", eth_speed); errors++; end
    phy_present = 1'b0;
    wait_frames(1);
    checks++; if (phy_err !== 1'b1)   begin $display("FAIL nophy_err: got %b, required 1", phy_err); errors++; end
    checks++; if (eth_speed !== 3'h2) begin $display("FAIL nophy_poll1_speed: got %h, required 2", eth_speed); errors++; end
    fs = frames_start;
    repeat (60) @(negedge clk_50m);
    checks++; if (frames_start != fs) begin $display("FAIL nophy_skip_spd: frames %0d, required %0d", frames_start, fs); errors++; end
    wait_frames(1);
    checks++; if (eth_speed !== 3'h0) begin $display("FAIL nophy_speed: got %h, required 0", eth_speed); errors++; end
    checks++; if (link_up !== 1'b0)   begin $display("FAIL nophy_link: got %b, required 0", link_up); errors++; end
    checks++; if (bridge_rst_n !== 1'b0) begin $display("FAIL nophy_bridge: got %b, required 0", bridge_rst_n); errors++; end
    phy_present = 1'b1;
    wait_frames(2);
    checks++; if (phy_err !== 1'b0)   begin $display("FAIL phy_err_clear: got %b, required 0", phy_err); errors++; end
  endtask

  task automatic test_reset_midframe();
    int t;
    bit found;
    t = 0;
    while (!(ifc.mdio_oe && bitcnt == 40) && t < 5000) begin
      @(negedge clk_50m);
      t++;
    end
    checks++; if (!(ifc.mdio_oe && bitcnt == 40)) begin $display("FAIL mid_reach_bit40: bit %0d, required 40", bitcnt); errors++; end
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.mdc !== 1'b0)     begin $display("FAIL mid_mdc: got %b, required 0", ifc.mdc); errors++; end
    checks++; if (ifc.mdio_o !== 1'b1)  begin $display("FAIL mid_mdio_o: got %b, required 1", ifc.mdio_o); errors++; end
    checks++; if (ifc.mdio_oe !== 1'b0) begin $display("FAIL mid_mdio_oe: got %b, required 0", ifc.mdio_oe); errors++; end
    checks++; if (eth_speed !== 3'h0 || link_up !== 1'b0 || bridge_rst_n !== 1'b0 || phy_err !== 1'b0) begin
      $display("FAIL mid_status: speed %h link %b brst %b err %b, required 0 0 0 0", eth_speed, link_up, bridge_rst_n, phy_err); errors++; end
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_50m); #1;
      if (ifc.mdio_oe) found = 1'b1;
    end
    checks++; if (!found) begin $display("FAIL mid_restart: oe %b, required 1 within 2 cycles", ifc.mdio_oe); errors++; end
    wait_frames(1);
    checks++; if (cap !== EXP_STAT) begin $display("FAIL mid_new_frame: got %h, required %h", cap, EXP_STAT); errors++; end
  endtask

  initial begin
    test_reset();
    test_frame_format();
    test_link_100();
    test_speed_change();
    test_link_drop();
    test_no_phy();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
